wash_run_ctrl: RTL

WASH_RUN_CTRL -- requirements
Module: wash_run_ctrl

---
 rtl/wash_pkg.sv | 73 +++++++
 rtl/rise_edge.sv | 33 +++
 rtl/wash_run_ctrl.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/wash_pkg.sv
// -----------------------------------------------------------------------------
// wash_pkg
// Shared constants for the washing-machine run controller:
//   - one-hot program codes presented by the mode selector
//   - one-hot phase codes, ordered {wash, rinse, spin}
//   - FSM state encoding
//   - default phase and buzzer durations, in ticks
// Helper functions decode a program code into its set of phases and walk
// that set in wash -> rinse -> spin order.
// -----------------------------------------------------------------------------
package wash_pkg;

    // Program select codes (one-hot, from the mode selector).
    localparam logic [5:0] MODE_FULL       = 6'b100000;  // wash + rinse + spin
    localparam logic [5:0] MODE_WASH       = 6'b010000;  // wash only
    localparam logic [5:0] MODE_WASH_RINSE = 6'b001000;  // wash + rinse
    localparam logic [5:0] MODE_RINSE_SPIN = 6'b000100;  // rinse + spin
    localparam logic [5:0] MODE_SPIN       = 6'b000010;  // spin only
    localparam logic [5:0] MODE_RINSE      = 6'b000001;  // rinse only

    // Phase codes; also used as a bit set of enabled phases.
    localparam logic [2:0] PH_NONE  = 3'b000;
    localparam logic [2:0] PH_WASH  = 3'b100;
    localparam logic [2:0] PH_RINSE = 3'b010;
    localparam logic [2:0] PH_SPIN  = 3'b001;

    // FSM state encoding.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Default durations in ticks.
    localparam int DEF_WASH_T  = 9;
    localparam int DEF_RINSE_T = 6;
    localparam int DEF_SPIN_T  = 3;
    localparam int DEF_BUZZ_T  = 4;

    // Set of phases a program runs; PH_NONE for anything that is not one of
    // the six legal one-hot codes.
    function automatic logic [2:0] mode_to_set(input logic [5:0] mode);
        logic [2:0] set;
        case (mode)
            MODE_FULL:       set = PH_WASH | PH_RINSE | PH_SPIN;
            MODE_WASH:       set = PH_WASH;
            MODE_WASH_RINSE: set = PH_WASH | PH_RINSE;
            MODE_RINSE_SPIN: set = PH_RINSE | PH_SPIN;
            MODE_SPIN:       set = PH_SPIN;
            MODE_RINSE:      set = PH_RINSE;
            default:         set = PH_NONE;
        endcase
        return set;
    endfunction

    // Earliest enabled phase in wash -> rinse -> spin order.
    function automatic logic [2:0] first_phase(input logic [2:0] set);
        logic [2:0] ph;
        if (set[2])      ph = PH_WASH;
        else if (set[1]) ph = PH_RINSE;
        else if (set[0]) ph = PH_SPIN;
        else             ph = PH_NONE;
        return ph;
    endfunction

    // Enabled phase following cur. For a one-hot cur, (cur - 1) masks in
    // exactly the later phases (the lower bits), so the priority pick of
    // first_phase yields the successor, or PH_NONE at the end of the program.
    function automatic logic [2:0] next_phase(input logic [2:0] set,
                                              input logic [2:0] cur);
        return first_phase(set & (cur - 3'd1));
    endfunction

endpackage

// File: rtl/rise_edge.sv
// -----------------------------------------------------------------------------
// rise_edge
// Registered rising-edge detector for an already-debounced level. The pulse
// is high for one cycle, in the cycle after the first clock edge that samples
// the level high.
// Ports:
//   clk   in   system clock
//   rst   in   synchronous, active-high reset; clears the history
//   d     in   level to watch
//   pulse out  one-cycle pulse following a 0 -> 1 transition of d
// -----------------------------------------------------------------------------
module rise_edge (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic pulse
);

    logic prev;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev  <= 1'b0;
            pulse <= 1'b0;
        end else begin
            prev  <= d;
            pulse <= d & ~prev;
        end
    end

endmodule

// File: rtl/wash_run_ctrl.sv
// -----------------------------------------------------------------------------
// wash_run_ctrl
// Program sequencer for a washing machine. A start/pause press with a legal
// one-hot mode launches a program made of up to three timed phases
// (wash, rinse, spin). Each 1 Hz tick counts the current phase and the
// program total down; further presses pause and resume. On completion a
// one-cycle finish pulse is issued and, optionally, a buzzer sounds.
//
// Build option:
//   WASH_BUZZER_EN  defined   : buzzer sounds for BUZZ_T ticks in DONE; a
//                               press in DONE silences it and returns to idle.
//                   undefined : buzzer tied low, DONE lasts a single cycle.
//
// Parameters:
//   WASH_T, RINSE_T, SPIN_T   phase lengths in ticks (sum <= 255)
//   BUZZ_T                    buzzer length in ticks
// Ports:
//   clk          in   system clock
//   rst          in   synchronous, active-high reset
//   power_on     in   low forces idle and clears all outputs
//   start_pause  in   debounced start/pause button level
//   mode         in   [5:0] one-hot program select
//   tick         in   one-cycle 1 Hz enable
//   flag_run     out  high while a program is running or paused
//   finish       out  one-cycle pulse at program completion
//   phase        out  [2:0] one-hot {wash, rinse, spin}, 000 when not running
//   remaining    out  [7:0] ticks left in the whole program
//   buzzer       out  completion alarm
// -----------------------------------------------------------------------------
module wash_run_ctrl
    import wash_pkg::*;
#(
    parameter int WASH_T  = DEF_WASH_T,
    parameter int RINSE_T = DEF_RINSE_T,
    parameter int SPIN_T  = DEF_SPIN_T,
    parameter int BUZZ_T  = DEF_BUZZ_T
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       power_on,
    input  logic       start_pause,
    input  logic [5:0] mode,
    input  logic       tick,
    output logic       flag_run,
    output logic       finish,
    output logic [2:0] phase,
    output logic [7:0] remaining,
    output logic       buzzer
);

    // ------------------------------------------------------------------
    // Elaboration checks: all counters are 8 bits wide.
    // ------------------------------------------------------------------
    if (WASH_T + RINSE_T + SPIN_T > 255) begin : g_sum_check
        $error("wash_run_ctrl: WASH_T + RINSE_T + SPIN_T exceeds 255");
    end
    if (WASH_T < 1 || RINSE_T < 1 || SPIN_T < 1) begin : g_len_check
        $error("wash_run_ctrl: every phase must last at least one tick");
    end
    if (BUZZ_T < 1 || BUZZ_T > 255) begin : g_buzz_check
        $error("wash_run_ctrl: BUZZ_T must lie in 1..255");
    end

    localparam logic [7:0] WASH_L  = 8'(WASH_T);
    localparam logic [7:0] RINSE_L = 8'(RINSE_T);
    localparam logic [7:0] SPIN_L  = 8'(SPIN_T);

    function automatic logic [7:0] phase_len(input logic [2:0] ph);
        logic [7:0] len;
        case (ph)
            PH_WASH:  len = WASH_L;
            PH_RINSE: len = RINSE_L;
            PH_SPIN:  len = SPIN_L;
            default:  len = 8'd0;
        endcase
        return len;
    endfunction

    // ------------------------------------------------------------------
    // Start/pause press detection.
    // ------------------------------------------------------------------
    logic start_edge;

    rise_edge u_start_edge (
        .clk   (clk),
        .rst   (rst),
        .d     (start_pause),
        .pulse (start_edge)
    );

    // ------------------------------------------------------------------
    // Program decode and phase sequencing.
    // ------------------------------------------------------------------
    logic [1:0] state;
    logic [2:0] phase_set;   // phases of the program latched at start
    logic [2:0] cur_phase;   // active phase, PH_NONE outside RUN/PAUSE
    logic [7:0] phase_cnt;   // ticks left in the active phase

    logic [2:0] start_set;
    logic [2:0] start_phase;
    logic [7:0] start_total;
    logic [2:0] succ_phase;
    logic       last_tick;   // current tick ends the active phase

    assign start_set   = mode_to_set(mode);
    assign start_phase = first_phase(start_set);
    assign start_total = (start_set[2] ? WASH_L  : 8'd0)
                       + (start_set[1] ? RINSE_L : 8'd0)
                       + (start_set[0] ? SPIN_L  : 8'd0);
    assign succ_phase  = next_phase(phase_set, cur_phase);
    assign last_tick   = (phase_cnt == 8'd1);

`ifdef WASH_BUZZER_EN
    logic [7:0] buzz_cnt;    // ticks of alarm left while in DONE
`endif

    // ------------------------------------------------------------------
    // Main FSM. Priority: rst, then power_on low, then start edge, then tick.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            phase_set <= PH_NONE;
            cur_phase <= PH_NONE;
            phase_cnt <= 8'd0;
            remaining <= 8'd0;
            finish    <= 1'b0;
`ifdef WASH_BUZZER_EN
            buzz_cnt  <= 8'd0;
`endif
        end else if (!power_on) begin
            state     <= ST_IDLE;
            phase_set <= PH_NONE;
            cur_phase <= PH_NONE;
            phase_cnt <= 8'd0;
            remaining <= 8'd0;
            finish    <= 1'b0;
`ifdef WASH_BUZZER_EN
            buzz_cnt  <= 8'd0;
`endif
        end else begin
            finish <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // An illegal mode decodes to an empty set and is ignored.
                    if (start_edge && start_set != PH_NONE) begin
                        state     <= ST_RUN;
                        phase_set <= start_set;
                        cur_phase <= start_phase;
                        phase_cnt <= phase_len(start_phase);
                        remaining <= start_total;
                    end
                end

                ST_RUN: begin
                    // A press wins over a coincident tick; that tick is lost.
                    if (start_edge) begin
                        state <= ST_PAUSE;
                    end else if (tick) begin
                        remaining <= remaining - 8'd1;
                        if (!last_tick) begin
                            phase_cnt <= phase_cnt - 8'd1;
                        end else if (succ_phase != PH_NONE) begin
                            cur_phase <= succ_phase;
                            phase_cnt <= phase_len(succ_phase);
                        end else begin
                            state     <= ST_DONE;
                            phase_set <= PH_NONE;
                            cur_phase <= PH_NONE;
                            phase_cnt <= 8'd0;
                            finish    <= 1'b1;
`ifdef WASH_BUZZER_EN
                            buzz_cnt  <= 8'(BUZZ_T);
`endif
                        end
                    end
                end

                ST_PAUSE: begin
                    if (start_edge) begin
                        state <= ST_RUN;
                    end
                end

                ST_DONE: begin
`ifdef WASH_BUZZER_EN
                    if (start_edge) begin
                        state    <= ST_IDLE;
                        buzz_cnt <= 8'd0;
                    end else if (tick) begin
                        if (buzz_cnt == 8'd1) begin
                            state <= ST_IDLE;
                        end
                        buzz_cnt <= buzz_cnt - 8'd1;
                    end
`else
                    state <= ST_IDLE;
`endif
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs.
    // ------------------------------------------------------------------
    assign flag_run = (state == ST_RUN) || (state == ST_PAUSE);
    assign phase    = flag_run ? cur_phase : PH_NONE;

`ifdef WASH_BUZZER_EN
    assign buzzer = (state == ST_DONE);
`else
    assign buzzer = 1'b0;
`endif

endmodule
